cmul_rr_arbiter: RTL

- Shares one complex_multiplier datapath (16-bit complex activation × 10-bit complex weight, pipelined, 16-bit complex result) among 4 requesters, for example per-beam VMM lanes.
- Round-robin grant, registered operand issue, and a tag pipeline matched to datapath latency so each result returns to the requester that issued it.
- Drain/flush sequencing lets the VMM controller quiesce the shared datapath before weight reload.

---
 rtl/cmul_rr_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/cmul_rr_arbiter.sv
// rtl/cmul_rr_arbiter.sv - round-robin share of one complex multiplier among 4 requesters, tag-matched results, drain/flush
// Optional grant counters under CMUL_RR_ARBITER_STATS_EN.
module cmul_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 3
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [63:0] a_real_flat,
  input  logic [63:0] a_imag_flat,
  input  logic [39:0] b_real_flat,
  input  logic [39:0] b_imag_flat,
  input  logic        flush,
  output logic [3:0]  gnt,
  output logic        mul_valid,
  output logic [15:0] mul_a_real,
  output logic [15:0] mul_a_imag,
  output logic [9:0]  mul_b_real,
  output logic [9:0]  mul_b_imag,
  input  logic [15:0] mul_z_real,
  input  logic [15:0] mul_z_imag,
  output logic [3:0]  rsp_valid,
  output logic [15:0] rsp_real,
  output logic [15:0] rsp_imag,
  output logic        busy,
  output logic        flush_done
`ifdef CMUL_RR_ARBITER_STATS_EN
  ,
  input  logic [1:0]  stat_sel,
  input  logic        stat_clr,
  output logic [15:0] stat_cnt
`endif
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [1:0]     r_ptr;
  logic [1:0]     r_mul_id;
  logic [LAT-1:0] r_tag_v;
  logic [1:0]     r_tag_id [LAT];

  logic [3:0]     w_elig;
  logic           w_found;
  logic [1:0]     w_win;
  logic [1:0]     w_cand;
  logic           w_arb_en;
  logic           w_grant;
  logic           w_inflight;

  assign w_elig     = req & ~gnt;
  assign w_grant    = w_arb_en & w_found;
  assign w_inflight = mul_valid | (|r_tag_v) | (|rsp_valid);
  assign busy       = w_inflight;

  // First eligible requester at or after the pointer, wrapping modulo 4.
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_cand  = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = r_ptr + 2'(k);
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (flush) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!w_inflight) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // A flush seen in RUN suppresses the grant at that same edge.
  always_comb begin
    w_arb_en   = 1'b0;
    flush_done = 1'b0;
    case (r_state)
      S_RUN:   w_arb_en = ~flush;
      S_DONE:  flush_done = 1'b1;
      default: w_arb_en = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst) begin
      gnt        <= '0;
      mul_valid  <= 1'b0;
      mul_a_real <= '0;
      mul_a_imag <= '0;
      mul_b_real <= '0;
      mul_b_imag <= '0;
      r_mul_id   <= '0;
      r_ptr      <= '0;
      r_tag_v    <= '0;
      for (int k = 0; k < LAT; k++) r_tag_id[k] <= '0;
      rsp_valid  <= '0;
      rsp_real   <= '0;
      rsp_imag   <= '0;
    end else begin
      if (w_grant) begin
        gnt        <= 4'b0001 << w_win;
        mul_valid  <= 1'b1;
        mul_a_real <= a_real_flat[16*w_win +: 16];
        mul_a_imag <= a_imag_flat[16*w_win +: 16];
        mul_b_real <= b_real_flat[10*w_win +: 10];
        mul_b_imag <= b_imag_flat[10*w_win +: 10];
        r_mul_id   <= w_win;
        r_ptr      <= w_win + 2'd1;
      end else begin
        gnt       <= '0;
        mul_valid <= 1'b0;
      end
      r_tag_v[0]  <= mul_valid;
      r_tag_id[0] <= r_mul_id;
      for (int k = 1; k < LAT; k++) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_id[k] <= r_tag_id[k-1];
      end
      if (r_tag_v[LAT-1]) begin
        rsp_valid <= 4'b0001 << r_tag_id[LAT-1];
        rsp_real  <= mul_z_real;
        rsp_imag  <= mul_z_imag;
      end else begin
        rsp_valid <= '0;
      end
    end
  end

`ifdef CMUL_RR_ARBITER_STATS_EN
  logic [15:0] r_stat [4];

  always_ff @(posedge CLK) begin
    if (!rst || stat_clr) begin
      for (int k = 0; k < 4; k++) r_stat[k] <= '0;
    end else if (w_grant && r_stat[w_win] != 16'hFFFF) begin
      r_stat[w_win] <= r_stat[w_win] + 16'd1;
    end
  end

  assign stat_cnt = r_stat[stat_sel];
`endif

endmodule
